// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector: FSM encoding,
// default length-field width and the pattern-length mask helper.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t ARMED = 1'b1;

  // Mask with the lowest len bits set; width covers the largest legal MAX_LEN.
  function automatic logic [31:0] len_mask(input logic [31:0] len);
    logic [31:0] m;
    m = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      m[i] = (i < len) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Counter register with clear/increment priority and saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && clr) begin
      count_r <= CNT_W'(1);
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: runtime-loaded pattern/length/overlap,
// registered match pulse and saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               enable,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  input  logic               count_clr
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state_r;
  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               match_r;
  logic               cfg_err_r;

  logic               cfg_len_ok_s;
  logic               cfg_accept_s;
  logic [MAX_LEN-1:0] hist_n_s;
  logic [LEN_W-1:0]   fill_n_s;
  logic [31:0]        mask_s;
  logic               hit_s;

  // Next-history, fill and hit evaluation for the current input bit.
  always_comb begin
    cfg_len_ok_s = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_MAX);
    cfg_accept_s = cfg_we && (state_r == IDLE) && cfg_len_ok_s;
    hist_n_s     = {hist_r[MAX_LEN-2:0], in_bit};
    if (fill_r >= LEN_MAX) begin
      fill_n_s = fill_r;
    end else begin
      fill_n_s = fill_r + LEN_W'(1);
    end
    mask_s = len_mask(32'(len_r));
    // Compare in the 32-bit domain so the full mask is consumed for any MAX_LEN.
    hit_s  = (state_r == ARMED) && in_valid && (fill_n_s >= len_r) &&
             ((32'(hist_n_s) & mask_s) == (32'(pattern_r) & mask_s));
  end

  // Config, FSM, history and match registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      pattern_r <= {MAX_LEN{1'b0}};
      len_r     <= LEN_W'(1);
      overlap_r <= 1'b0;
      hist_r    <= {MAX_LEN{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we && !cfg_accept_s;
      if (cfg_accept_s) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
      end
      match_r <= hit_s;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= ARMED;
            hist_r  <= {MAX_LEN{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
          end
        end
        ARMED: begin
          if (!enable) begin
            state_r <= IDLE;
          end
          // A non-overlapping hit only clears fill; stale history is then gated off.
          if (in_valid) begin
            hist_r <= hist_n_s;
            fill_r <= (hit_s && !overlap_r) ? {LEN_W{1'b0}} : fill_n_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_s),
    .clr   (count_clr),
    .count (match_count)
  );

  assign armed   = (state_r == ARMED);
  assign match   = match_r;
  assign cfg_err = cfg_err_r;

endmodule
